// File: rtl/axi_slave_ram.sv
// axi_slave_ram: AXI4 slave terminating a word-addressed RAM behind one
// address window. Handles INCR, FIXED and WRAP bursts with byte strobes.
// Beats outside the window return DECERR; illegal burst encodings return
// SLVERR (SLVERR wins over DECERR in the write response).
//
// Ports:
//   aclk, aresetn                 clock, asynchronous active-low reset
//   axi_aw*  / axi_awready        write address channel
//   axi_w*   / axi_wready         write data channel
//   axi_b*   / axi_bready         write response channel
//   axi_ar*  / axi_arready        read address channel
//   axi_r*   / axi_rready         read data channel
//   wr_state, rd_state            write / read FSM state, for observation
//
// Handshake rule on every channel: a transfer happens on the rising edge
// where valid and ready are both high; a source holds valid and payload
// stable until that edge, and ready never depends on valid from this side.
module axi_slave_ram #(
  parameter int                        AXI_ID_WIDTH   = 1,
  parameter int                        AXI_DATA_WIDTH = 32,
  parameter int                        AXI_ADDR_WIDTH = 32,
  parameter int                        MEM_DEPTH      = 256,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = '0
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [AXI_ID_WIDTH-1:0]     axi_awid,
  input  logic [AXI_ADDR_WIDTH-1:0]   axi_awaddr,
  input  logic [7:0]                  axi_awlen,
  input  logic [2:0]                  axi_awsize,
  input  logic [1:0]                  axi_awburst,
  input  logic                        axi_awvalid,
  output logic                        axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0]   axi_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] axi_wstrb,
  input  logic                        axi_wlast,
  input  logic                        axi_wvalid,
  output logic                        axi_wready,
  output logic [AXI_ID_WIDTH-1:0]     axi_bid,
  output logic [1:0]                  axi_bresp,
  output logic                        axi_bvalid,
  input  logic                        axi_bready,
  input  logic [AXI_ID_WIDTH-1:0]     axi_arid,
  input  logic [AXI_ADDR_WIDTH-1:0]   axi_araddr,
  input  logic [7:0]                  axi_arlen,
  input  logic [2:0]                  axi_arsize,
  input  logic [1:0]                  axi_arburst,
  input  logic                        axi_arvalid,
  output logic                        axi_arready,
  output logic [AXI_ID_WIDTH-1:0]     axi_rid,
  output logic [AXI_DATA_WIDTH-1:0]   axi_rdata,
  output logic [1:0]                  axi_rresp,
  output logic                        axi_rlast,
  output logic                        axi_rvalid,
  input  logic                        axi_rready,
  output logic [1:0]                  wr_state,
  output logic                        rd_state
);

  localparam int                        IDX_W     = $clog2(MEM_DEPTH);
  localparam logic [AXI_ADDR_WIDTH-1:0] WIN_BYTES = AXI_ADDR_WIDTH'(MEM_DEPTH * 4);

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_e;
  typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;

  function automatic logic in_window(input logic [AXI_ADDR_WIDTH-1:0] addr);
    in_window = (addr - BASE_ADDR) < WIN_BYTES;
  endfunction

  function automatic logic [IDX_W-1:0] word_index(input logic [AXI_ADDR_WIDTH-1:0] addr);
    word_index = IDX_W'((addr - BASE_ADDR) >> 2);
  endfunction

  // WRAP: the low bits covered by the (len+1)*4 byte container increment,
  // the bits above it stay put. Only legal WRAP lengths reach here with data.
  function automatic logic [AXI_ADDR_WIDTH-1:0] next_addr(
    input logic [AXI_ADDR_WIDTH-1:0] addr,
    input logic [7:0]                len,
    input logic [1:0]                burst
  );
    logic [AXI_ADDR_WIDTH-1:0] inc;
    logic [AXI_ADDR_WIDTH-1:0] mask;
    inc  = addr + AXI_ADDR_WIDTH'(4);
    mask = AXI_ADDR_WIDTH'({len, 2'b11});
    case (burst)
      2'b00:   next_addr = addr;
      2'b10:   next_addr = (addr & ~mask) | (inc & mask);
      default: next_addr = inc;
    endcase
  endfunction

  function automatic logic decode_err(input logic [2:0] size, input logic [1:0] burst,
                                      input logic [7:0] len);
    decode_err = (size != 3'b010) || (burst == 2'b11) ||
                 ((burst == 2'b10) && !((len == 8'd1) || (len == 8'd3) ||
                                        (len == 8'd7) || (len == 8'd15)));
  endfunction

  logic [AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Low during reset and for nothing else: keeps the address-channel
  // readies at 0 while aresetn is asserted even though the FSMs sit idle.
  logic ready_en;
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) ready_en <= 1'b0;
    else          ready_en <= 1'b1;
  end

  // ---------------- write channel ----------------
  w_state_e                  w_state, w_state_nxt;
  logic [AXI_ADDR_WIDTH-1:0] w_addr;
  logic [7:0]                w_len, w_cnt;
  logic [1:0]                w_burst;
  logic                      w_decode, w_slv, w_dec;
  logic                      aw_hs, w_hs, w_last_beat;

  assign aw_hs       = axi_awvalid && axi_awready;
  assign w_hs        = axi_wvalid && axi_wready;
  assign w_last_beat = (w_cnt == w_len);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) w_state <= W_IDLE;
    else          w_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs) w_state_nxt = W_DATA;
      W_DATA:  if (w_hs && w_last_beat) w_state_nxt = W_RESP;
      W_RESP:  if (axi_bready) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    axi_awready = (w_state == W_IDLE) && ready_en;
    axi_wready  = (w_state == W_DATA);
    axi_bvalid  = (w_state == W_RESP);
    axi_bresp   = w_slv ? 2'b10 : (w_dec ? 2'b11 : 2'b00);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_addr   <= '0;
      w_len    <= '0;
      w_cnt    <= '0;
      w_burst  <= '0;
      w_decode <= 1'b0;
      w_slv    <= 1'b0;
      w_dec    <= 1'b0;
      axi_bid  <= '0;
    end else if (aw_hs) begin
      w_addr   <= axi_awaddr;
      w_len    <= axi_awlen;
      w_cnt    <= '0;
      w_burst  <= axi_awburst;
      w_decode <= decode_err(axi_awsize, axi_awburst, axi_awlen);
      w_slv    <= decode_err(axi_awsize, axi_awburst, axi_awlen);
      w_dec    <= 1'b0;
      axi_bid  <= axi_awid;
    end else if (w_hs) begin
      w_addr <= next_addr(w_addr, w_len, w_burst);
      w_cnt  <= w_cnt + 8'd1;
      // wlast must coincide exactly with the counted final beat
      if (axi_wlast != w_last_beat) w_slv <= 1'b1;
      if (!in_window(w_addr))       w_dec <= 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (w_hs && in_window(w_addr) && !w_decode) begin
      for (int b = 0; b < AXI_DATA_WIDTH / 8; b++) begin
        if (axi_wstrb[b]) mem[word_index(w_addr)][8*b +: 8] <= axi_wdata[8*b +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  r_state_e                  r_state, r_state_nxt;
  logic [AXI_ADDR_WIDTH-1:0] r_addr, ld_addr;
  logic [7:0]                r_len, r_cnt;
  logic [1:0]                r_burst;
  logic                      r_decode, ld_slv;
  logic                      ar_hs, r_adv;

  assign ar_hs   = axi_arvalid && axi_arready;
  assign r_adv   = axi_rvalid && axi_rready && !axi_rlast;
  // The beat presented next: first beat from AR, later beats stepped
  assign ld_addr = ar_hs ? axi_araddr : next_addr(r_addr, r_len, r_burst);
  assign ld_slv  = ar_hs ? decode_err(axi_arsize, axi_arburst, axi_arlen) : r_decode;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= R_IDLE;
    else          r_state <= r_state_nxt;
  end

  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_state_nxt = R_DATA;
      R_DATA:  if (axi_rready && axi_rlast) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    axi_arready = (r_state == R_IDLE) && ready_en;
    axi_rvalid  = (r_state == R_DATA);
  end

  // Read data is registered from the RAM, so a write to the same word on
  // the same edge is not visible to this beat.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_addr    <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_burst   <= '0;
      r_decode  <= 1'b0;
      axi_rid   <= '0;
      axi_rlast <= 1'b0;
      axi_rdata <= '0;
      axi_rresp <= 2'b00;
    end else if (ar_hs || r_adv) begin
      r_addr <= ld_addr;
      if (ar_hs) begin
        r_len     <= axi_arlen;
        r_cnt     <= '0;
        r_burst   <= axi_arburst;
        r_decode  <= decode_err(axi_arsize, axi_arburst, axi_arlen);
        axi_rid   <= axi_arid;
        axi_rlast <= (axi_arlen == 8'd0);
      end else begin
        r_cnt     <= r_cnt + 8'd1;
        axi_rlast <= ((r_cnt + 8'd1) == r_len);
      end
      if (ld_slv) begin
        axi_rdata <= '0;
        axi_rresp <= 2'b10;
      end else if (!in_window(ld_addr)) begin
        axi_rdata <= '0;
        axi_rresp <= 2'b11;
      end else begin
        axi_rdata <= mem[word_index(ld_addr)];
        axi_rresp <= 2'b00;
      end
    end
  end

  assign wr_state = w_state;
  assign rd_state = r_state;

endmodule
